// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit seven-segment driver with per-frame input latching,
// leading-zero blanking, decimal points and a digit enable mask.
module seven_seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int IDX_W    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bcd,
  input  logic [7:0]  dp,
  input  logic [7:0]  en,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]    presc;
  logic [IDX_W-1:0] idx;
  logic             load_pend;
  logic [31:0]      bcd_f;
  logic [7:0]       dp_f;
  logic [7:0]       en_f;
  logic             blz_f;

  logic             tick;
  logic             load;
  logic [3:0]       nibble;
  logic [7:0]       zero_above;
  logic             dark;

  // Segment pattern {g,f,e,d,c,b,a}, active low; non-BCD codes get hex glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign tick = (presc == PRESC_LAST);
  assign load = load_pend | (tick & (idx == IDX_W'(7)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // A frame is captured only at scan wrap so one display never mixes two words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend   <= 1'b1;
      bcd_f       <= '0;
      dp_f        <= '0;
      en_f        <= '0;
      blz_f       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      load_pend   <= 1'b0;
      frame_start <= load;
      if (load) begin
        bcd_f <= bcd;
        dp_f  <= dp;
        en_f  <= en;
        blz_f <= blank_lz;
      end
    end
  end

  always_comb begin
    zero_above = '0;
    for (int k = 0; k < 8; k++) begin
      zero_above[k] = ((bcd_f >> (4 * k)) == 32'h0);
    end
    nibble = bcd_f[{idx, 2'b00} +: 4];
    dark   = !en_f[idx] || (blz_f && (idx != '0) && zero_above[idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else if (dark) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= {~dp_f[idx], glyph(nibble)};
    end
  end

endmodule
